// File: rtl/bus_transfer_sequencer.sv
// Command FIFO plus sequencer that steers a 32:1 bus mux and pulses one destination load.
// Define BUS_SETTLE_EN to insert a bus-settle (DRIVE) cycle ahead of every load.
module bus_transfer_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic [4:0]  bus_sel,
  output logic [31:0] dst_ld,
  output logic        busy,
  output logic        src_err,
  output logic [2:0]  fifo_count
);

`ifdef BUS_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LOAD} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_LOAD} state_t;
`endif

  localparam logic [4:0] SEL_IDLE = 5'd31;
  localparam logic [4:0] SRC_MAX  = 5'd23;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_fifo_src [4];
  logic [4:0]  r_fifo_dst [4];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_count;
  logic [4:0]  r_bus_sel, w_sel_nxt;
  logic [31:0] r_dst_ld, w_ld_nxt;
  logic        r_src_err, w_err_nxt;
  logic        w_push, w_pop;
  logic [4:0]  w_head_src, w_head_dst;
`ifdef BUS_SETTLE_EN
  logic [4:0]  r_dst, w_dst_nxt;
`endif

  assign req_ready  = (r_count != 3'd4);
  assign w_push     = req_valid && req_ready;
  assign w_head_src = r_fifo_src[r_rptr];
  assign w_head_dst = r_fifo_dst[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_bus_sel;
    w_ld_nxt    = r_dst_ld;
    w_err_nxt   = 1'b0;
    w_pop       = 1'b0;
`ifdef BUS_SETTLE_EN
    w_dst_nxt   = r_dst;
    if (r_state == S_DRIVE) begin
      w_state_nxt = S_LOAD;
      w_ld_nxt    = 32'd1 << r_dst;
    end else
`endif
    if (r_count != 3'd0) begin
      // IDLE and LOAD both pop the head; LOAD chains straight into the next transfer
      w_pop = 1'b1;
      if (w_head_src <= SRC_MAX) begin
        w_sel_nxt = w_head_src;
`ifdef BUS_SETTLE_EN
        w_state_nxt = S_DRIVE;
        w_ld_nxt    = '0;
        w_dst_nxt   = w_head_dst;
`else
        w_state_nxt = S_LOAD;
        w_ld_nxt    = 32'd1 << w_head_dst;
`endif
      end else begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = SEL_IDLE;
        w_ld_nxt    = '0;
        w_err_nxt   = 1'b1;
      end
    end else begin
      w_state_nxt = S_IDLE;
      w_sel_nxt   = SEL_IDLE;
      w_ld_nxt    = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_bus_sel <= SEL_IDLE;
      r_dst_ld  <= '0;
      r_src_err <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
`ifdef BUS_SETTLE_EN
      r_dst     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bus_sel <= w_sel_nxt;
      r_dst_ld  <= w_ld_nxt;
      r_src_err <= w_err_nxt;
`ifdef BUS_SETTLE_EN
      r_dst     <= w_dst_nxt;
`endif
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_src[r_wptr] <= req_src;
      r_fifo_dst[r_wptr] <= req_dst;
    end
  end

  assign bus_sel    = r_bus_sel;
  assign dst_ld     = r_dst_ld;
  assign src_err    = r_src_err;
  assign fifo_count = r_count;
  assign busy       = (r_count != 3'd0) || (r_state != S_IDLE);

endmodule

// File: doc/bus_transfer_sequencer.md
BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `clr`; `clr` is asynchronous and active-high.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- `clk` -- in -- 1 -- rising-edge clock.
- `clr` -- in -- 1 -- asynchronous active-high reset.
- `req_valid` -- in -- 1 -- transfer command offered.
- `req_ready` -- out -- 1 -- command FIFO can accept.
- `req_src` -- in -- 5 -- bus source index, drives the 32:1 bus mux select (0-23 legal).
- `req_dst` -- in -- 5 -- destination register index 0-31.
- `bus_sel` -- out -- 5 -- select to the bus mux, registered.
- `dst_ld` -- out -- 32 -- one-hot destination load enable, registered.
- `busy` -- out -- 1 -- FIFO non-empty or transfer in progress.
- `src_err` -- out -- 1 -- one-cycle pulse when an illegal source is dropped.
- `fifo_count` -- out -- 3 -- FIFO occupancy, 0-4.

Function
REQ-003 Commands SHALL be buffered in a 4-entry FIFO of {src, dst}, accepted on a rising edge where `req_valid` and `req_ready` are both 1.
REQ-004 `req_ready` SHALL equal (`fifo_count` != 4), computed from registered count only.
- With the FIFO full, a simultaneous pop does not enable a push in the same cycle.
REQ-005 The FSM SHALL have states IDLE, DRIVE and LOAD; DRIVE exists only when BUS_SETTLE_EN is defined (see REQ-014).
REQ-006 From IDLE with the FIFO non-empty, the block SHALL pop the head and transition at the next edge:
- head src <= 23: go to DRIVE, with `bus_sel` = src and `dst_ld` = 0.
- head src >= 24: drop the command, pulse `src_err` for one cycle, stay in IDLE.
REQ-007 From DRIVE, the FSM SHALL unconditionally go to LOAD.
- In LOAD, `bus_sel` is held and `dst_ld` has exactly bit [dst] set.
REQ-008 From LOAD, the FSM SHALL:
- pop the next head if the FIFO is non-empty, applying the REQ-006 rules, entering DRIVE directly (legal src) or IDLE (illegal src);
- otherwise go to IDLE.
REQ-009 In IDLE, `bus_sel` SHALL be 5'd31 (bus mux outputs zero) and `dst_ld` SHALL be 0.
REQ-010 Latency with BUS_SETTLE_EN defined:
- command pushed at edge N on an empty, idle block;
- `bus_sel` valid from edge N+1;
- `dst_ld` asserted for cycle N+2 to N+3 only;
- sustained throughput is one transfer per 2 cycles.
REQ-011 `fifo_count` SHALL reflect push and pop in the same edge: a simultaneous push and pop leaves the count unchanged.
REQ-012 `busy` SHALL be high whenever `fifo_count` != 0 or the state != IDLE.

Reset
REQ-013 While `clr` = 1, regardless of `clk`, the block SHALL:
- empty the FIFO, with `fifo_count` = 0 and `req_ready` = 1;
- set the state to IDLE, `bus_sel` = 5'd31, `dst_ld` = 0, `src_err` = 0 and `busy` = 0;
- abort any in-flight transfer mid-DRIVE or mid-LOAD with no further `dst_ld` pulse.

Configuration
REQ-014 The macro `BUS_SETTLE_EN` SHALL compile the bus-settle cycle in or out:
- Defined: the DRIVE-then-LOAD sequence of REQ-006 to REQ-008 applies.
- Undefined: the DRIVE state is removed. A pop from IDLE or LOAD goes directly to LOAD, with `bus_sel` and `dst_ld` updated on the same edge. Latency is `dst_ld` in cycle N+1, and throughput is one transfer per cycle.

Verification
REQ-015 The bench SHALL cover these directed scenarios (BUS_SETTLE_EN defined unless stated):
- Single transfer: push src=3, dst=7 at edge 0 -> `bus_sel` = 3 from edge 1; `dst_ld` = 32'h80 for exactly cycle 2; IDLE with `bus_sel` = 31 at edge 3.
- Fill: push 5 commands back-to-back with the block stalled by reset release timing -> `req_ready` = 0 after 4 accepted; `fifo_count` = 4; 5th accepted only after the first pop; all transfers appear in order at 2 cycles each.
- Illegal source: push src=25, dst=2, then src=16, dst=4 -> one `src_err` pulse; no load of bit 2; `dst_ld` = 32'h10 with `bus_sel` = 16.
- Reset mid-LOAD: assert `clr` asynchronously between edges during LOAD with 2 commands queued -> `dst_ld` = 0 immediately; `fifo_count` = 0; no further loads after release.
- BUS_SETTLE_EN undefined: push src=19 (Zlow), dst=0 and then src=21 (MDR), dst=31 on consecutive edges -> `dst_ld` = 32'h1 then 32'h80000000 in consecutive cycles.
